writeback_queue: RTL and testbench

Write-side driver for the MIPS register file. Accepts completed results from the MEM/WB stage through a valid/ready handshake, selects ALU or memory data, buffers them in order, and drives the register file's write port (`regWrite`/`writeRegister`/`writeData`) one write per cycle. It also reports, per read address, whether a write to that register is still in flight, so the hazard unit can stall dependent reads.

---
 rtl/writeback_queue_if.sv | 42 ++++
 rtl/writeback_queue.sv | 93 +++++++++
 tb/tb_writeback_queue.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_queue_if.sv
`default_nettype none
// ============================================================================
// Module : writeback_queue_if
// Desc   : MEM/WB result bus, register-file write port and hazard query
//          signals for writeback_queue.
// Rev    : 1.0  initial release
// ============================================================================
interface writeback_queue_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
);
    logic                    inValid;
    logic                    inReady;
    logic                    inMemToReg;
    logic [4:0]              inDest;
    logic [DATA_W-1:0]       inAluResult;
    logic [DATA_W-1:0]       inMemData;
    logic                    drainEnable;
    logic                    regWrite;
    logic [4:0]              writeRegister;
    logic [DATA_W-1:0]       writeData;
    logic [4:0]              regA;
    logic [4:0]              regB;
    logic                    pendingA;
    logic                    pendingB;
    logic [$clog2(DEPTH):0]  count;

    modport master (
        output inValid, inMemToReg, inDest, inAluResult, inMemData,
               drainEnable, regA, regB,
        input  inReady, regWrite, writeRegister, writeData,
               pendingA, pendingB, count
    );

    modport slave (
        input  inValid, inMemToReg, inDest, inAluResult, inMemData,
               drainEnable, regA, regB,
        output inReady, regWrite, writeRegister, writeData,
               pendingA, pendingB, count
    );
endinterface
`default_nettype wire

// File: rtl/writeback_queue.sv
`default_nettype none
// ============================================================================
// Module : writeback_queue
// Desc   : In-order write-back buffer driving the register-file write port,
//          with per-read-address outstanding-write reporting.
// Rev    : 1.0  initial release
// ============================================================================
module writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    writeback_queue_if.slave  bus
);
    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);

    logic [4:0]         r_dest [DEPTH];
    logic [DATA_W-1:0]  r_data [DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_regwrite;
    logic [4:0]         r_wreg;
    logic [DATA_W-1:0]  r_wdata;

    logic               w_ready;
    logic               w_push;
    logic               w_pop;
    logic [DATA_W-1:0]  w_sel;
    logic [DEPTH-1:0]   w_hit_a;
    logic [DEPTH-1:0]   w_hit_b;

    assign w_ready = !reset && (r_count < c_FULL);
    assign w_sel   = bus.inMemToReg ? bus.inMemData : bus.inAluResult;
    // r0 writes complete the handshake but never occupy a slot.
    assign w_push  = bus.inValid && w_ready && (bus.inDest != 5'd0);
    assign w_pop   = (r_count != '0) && bus.drainEnable;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_dest[r_wptr] <= bus.inDest;
            r_data[r_wptr] <= w_sel;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_regwrite <= 1'b0;
            r_wreg     <= '0;
            r_wdata    <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_regwrite <= w_pop;
            if (w_pop) begin
                r_wreg  <= r_dest[r_rptr];
                r_wdata <= r_data[r_rptr];
            end
        end
    end

    // A slot is live when its distance from the read pointer is below count.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_occ
        logic [c_PTR_W-1:0] w_off;
        logic               w_live;
        assign w_off        = c_PTR_W'(gi) - r_rptr;
        assign w_live       = ({1'b0, w_off} < r_count);
        assign w_hit_a[gi]  = w_live && (r_dest[gi] == bus.regA);
        assign w_hit_b[gi]  = w_live && (r_dest[gi] == bus.regB);
    end

    assign bus.inReady       = w_ready;
    assign bus.regWrite      = r_regwrite;
    assign bus.writeRegister = r_wreg;
    assign bus.writeData     = r_wdata;
    assign bus.count         = r_count;
    assign bus.pendingA      = (bus.regA != 5'd0) &&
                               ((|w_hit_a) || (r_regwrite && (r_wreg == bus.regA)));
    assign bus.pendingB      = (bus.regB != 5'd0) &&
                               ((|w_hit_b) || (r_regwrite && (r_wreg == bus.regB)));
endmodule
`default_nettype wire

// File: tb/tb_writeback_queue.sv
`default_nettype none
// tb_writeback_queue: vector table, directed corner sequences and random
// traffic compared against a queue-based model of the write-back path.
module tb_writeback_queue;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    writeback_queue_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus();

    writeback_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [4:0]  dest;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        logic [4:0]  dest;
        logic [31:0] data;
        int          cyc;
    } log_t;

    typedef struct {
        logic        v;
        logic        mtr;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic [31:0] mem;
        logic        drain;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic        e_rw;
        logic [4:0]  e_wreg;
        logic [31:0] e_wdata;
        logic [2:0]  e_cnt;
        logic        e_rdy;
        logic        e_pa;
        logic        e_pb;
    } vec_t;

    ent_t        mq[$];
    log_t        wr_log[$];
    logic        m_rw;
    logic [4:0]  m_wreg;
    logic [31:0] m_wdata;
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    vec_t        vt[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic m_pending(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        if (m_rw && m_wreg == r) return 1'b1;
        foreach (mq[i]) if (mq[i].dest == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_rw    = 1'b0;
        m_wreg  = 5'd0;
        m_wdata = 32'd0;
    endtask

    task automatic drive(input logic v, input logic mtr, input logic [4:0] d,
                         input logic [31:0] alu, input logic [31:0] mem,
                         input logic dr, input logic [4:0] ra, input logic [4:0] rb);
        bus.inValid     = v;
        bus.inMemToReg  = mtr;
        bus.inDest      = d;
        bus.inAluResult = alu;
        bus.inMemData   = mem;
        bus.drainEnable = dr;
        bus.regA        = ra;
        bus.regB        = rb;
    endtask

    // Check current outputs against the model, clock once, advance the model.
    task automatic cycle();
        logic push, pop;
        ent_t e, h;
        #1;
        chk("inReady",       32'(bus.inReady),       32'(mq.size() < DEPTH));
        chk("count",         32'(bus.count),         32'(mq.size()));
        chk("regWrite",      32'(bus.regWrite),      32'(m_rw));
        chk("writeRegister", 32'(bus.writeRegister), 32'(m_wreg));
        chk("writeData",     bus.writeData,          m_wdata);
        chk("pendingA",      32'(bus.pendingA),      32'(m_pending(bus.regA)));
        chk("pendingB",      32'(bus.pendingB),      32'(m_pending(bus.regB)));
        push   = bus.inValid && (mq.size() < DEPTH) && (bus.inDest != 5'd0);
        pop    = (mq.size() != 0) && bus.drainEnable;
        e.dest = bus.inDest;
        e.data = bus.inMemToReg ? bus.inMemData : bus.inAluResult;
        @(posedge clk);
        if (pop) begin
            h       = mq.pop_front();
            m_rw    = 1'b1;
            m_wreg  = h.dest;
            m_wdata = h.data;
        end else begin
            m_rw = 1'b0;
        end
        if (push) mq.push_back(e);
        cyc++;
        @(negedge clk);
        #1;
        if (bus.regWrite) wr_log.push_back('{bus.writeRegister, bus.writeData, cyc});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   n;
        int   max_cnt;
        logic saw_dead;

        reset = 1'b1;
        drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 5'd0);
        model_reset();
        #12;
        chk("rst_regWrite", 32'(bus.regWrite),      32'd0);
        chk("rst_wreg",     32'(bus.writeRegister), 32'd0);
        chk("rst_wdata",    bus.writeData,          32'd0);
        chk("rst_count",    32'(bus.count),         32'd0);
        chk("rst_inReady",  32'(bus.inReady),       32'd0);
        chk("rst_pendingA", 32'(bus.pendingA),      32'd0);
        @(negedge clk);
        reset = 1'b0;

        // ---------------- vector table ----------------
        vt[0] = '{1'b1, 1'b0, 5'd8, 32'h2A,   32'h77, 1'b1, 5'd8, 5'd0, 1'b0, 5'd0, 32'h00, 3'd1, 1'b1, 1'b1, 1'b0};
        vt[1] = '{1'b0, 1'b0, 5'd0, 32'h0,    32'h0,  1'b1, 5'd8, 5'd0, 1'b1, 5'd8, 32'h2A, 3'd0, 1'b1, 1'b1, 1'b0};
        vt[2] = '{1'b0, 1'b0, 5'd0, 32'h0,    32'h0,  1'b1, 5'd8, 5'd0, 1'b0, 5'd8, 32'h2A, 3'd0, 1'b1, 1'b0, 1'b0};
        vt[3] = '{1'b1, 1'b0, 5'd0, 32'h5,    32'h0,  1'b1, 5'd0, 5'd0, 1'b0, 5'd8, 32'h2A, 3'd0, 1'b1, 1'b0, 1'b0};
        vt[4] = '{1'b0, 1'b0, 5'd0, 32'h0,    32'h0,  1'b1, 5'd0, 5'd0, 1'b0, 5'd8, 32'h2A, 3'd0, 1'b1, 1'b0, 1'b0};
        vt[5] = '{1'b1, 1'b1, 5'd3, 32'hDEAD, 32'h55, 1'b0, 5'd3, 5'd8, 1'b0, 5'd8, 32'h2A, 3'd1, 1'b1, 1'b1, 1'b0};
        vt[6] = '{1'b0, 1'b0, 5'd0, 32'h0,    32'h0,  1'b0, 5'd3, 5'd8, 1'b0, 5'd8, 32'h2A, 3'd1, 1'b1, 1'b1, 1'b0};
        vt[7] = '{1'b0, 1'b0, 5'd0, 32'h0,    32'h0,  1'b1, 5'd3, 5'd8, 1'b1, 5'd3, 32'h55, 3'd0, 1'b1, 1'b1, 1'b0};
        vt[8] = '{1'b0, 1'b0, 5'd0, 32'h0,    32'h0,  1'b1, 5'd3, 5'd3, 1'b0, 5'd3, 32'h55, 3'd0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 9; i++) begin
            drive(vt[i].v, vt[i].mtr, vt[i].dest, vt[i].alu, vt[i].mem,
                  vt[i].drain, vt[i].ra, vt[i].rb);
            cycle();
            chk($sformatf("vec%0d_regWrite", i), 32'(bus.regWrite),      32'(vt[i].e_rw));
            chk($sformatf("vec%0d_wreg", i),     32'(bus.writeRegister), 32'(vt[i].e_wreg));
            chk($sformatf("vec%0d_wdata", i),    bus.writeData,          vt[i].e_wdata);
            chk($sformatf("vec%0d_count", i),    32'(bus.count),         32'(vt[i].e_cnt));
            chk($sformatf("vec%0d_inReady", i),  32'(bus.inReady),       32'(vt[i].e_rdy));
            chk($sformatf("vec%0d_pendingA", i), 32'(bus.pendingA),      32'(vt[i].e_pa));
            chk($sformatf("vec%0d_pendingB", i), 32'(bus.pendingB),      32'(vt[i].e_pb));
        end

        // ---------------- full and backpressure ----------------
        wr_log.delete();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 5'(9 + i), 32'(i + 1), 32'hFFFF, 1'b0, 5'd0, 5'd0);
            cycle();
        end
        drive(1'b1, 1'b0, 5'd13, 32'd5, 32'hFFFF, 1'b0, 5'd0, 5'd0);
        cycle();
        chk("full_count",   32'(bus.count),   32'd4);
        chk("full_inReady", 32'(bus.inReady), 32'd0);
        bus.drainEnable = 1'b1;
        cycle();
        chk("ready_after_pop", 32'(bus.inReady), 32'd1);
        cycle();
        bus.inValid = 1'b0;
        n = 0;
        while (wr_log.size() < 5 && n < 12) begin
            cycle();
            n++;
        end
        chk("full_write_total", 32'(wr_log.size()), 32'd5);
        for (int i = 0; i < 5 && i < wr_log.size(); i++) begin
            chk($sformatf("full_order_dest%0d", i), 32'(wr_log[i].dest), 32'(9 + i));
            chk($sformatf("full_order_data%0d", i), wr_log[i].data,      32'(i + 1));
            if (i > 0 && i < 4)
                chk($sformatf("full_consecutive%0d", i), 32'(wr_log[i].cyc - wr_log[i-1].cyc), 32'd1);
        end

        // ---------------- pending tracking ----------------
        wr_log.delete();
        drive(1'b1, 1'b0, 5'd16, 32'd1, 32'd0, 1'b0, 5'd16, 5'd17);
        cycle();
        bus.inAluResult = 32'd2;
        cycle();
        bus.inValid = 1'b0;
        cycle();
        chk("pend_queued_A", 32'(bus.pendingA), 32'd1);
        chk("pend_queued_B", 32'(bus.pendingB), 32'd0);
        bus.drainEnable = 1'b1;
        n = 0;
        while (wr_log.size() < 2 && n < 10) begin
            cycle();
            n++;
        end
        chk("pend_writes", 32'(wr_log.size()), 32'd2);
        chk("pend_last_data",  bus.writeData,        32'd2);
        chk("pend_during_last", 32'(bus.pendingA),   32'd1);
        cycle();
        chk("pend_cleared_A", 32'(bus.pendingA), 32'd0);
        chk("pend_never_B",   32'(bus.pendingB), 32'd0);

        // ---------------- memory select and streaming ----------------
        wr_log.delete();
        max_cnt  = 0;
        saw_dead = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 5'(20 + i), 32'hDEAD, 32'(32'h100 + i), 1'b1, 5'd0, 5'd0);
            cycle();
            if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
        end
        bus.inValid = 1'b0;
        cycle();
        cycle();
        chk("stream_writes", 32'(wr_log.size()), 32'd8);
        chk("stream_max_count", 32'(max_cnt), 32'd1);
        for (int i = 0; i < wr_log.size(); i++) begin
            if (wr_log[i].data == 32'hDEAD) saw_dead = 1'b1;
            if (i < 8) begin
                chk($sformatf("stream_data%0d", i), wr_log[i].data, 32'(32'h100 + i));
                if (i > 0)
                    chk($sformatf("stream_consecutive%0d", i), 32'(wr_log[i].cyc - wr_log[i-1].cyc), 32'd1);
            end
        end
        chk("stream_no_alu", 32'(saw_dead), 32'd0);

        // ---------------- reset mid-operation ----------------
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 5'(4 + i), 32'(32'h40 + i), 32'd0, 1'b0, 5'd6, 5'd7);
            cycle();
        end
        drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd6, 5'd7);
        cycle();
        chk("mid_pre_count",    32'(bus.count),    32'd3);
        chk("mid_pre_regWrite", 32'(bus.regWrite), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_regWrite", 32'(bus.regWrite), 32'd0);
        chk("mid_count",    32'(bus.count),    32'd0);
        chk("mid_pendingA", 32'(bus.pendingA), 32'd0);
        chk("mid_pendingB", 32'(bus.pendingB), 32'd0);
        chk("mid_inReady",  32'(bus.inReady),  32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        wr_log.delete();
        for (int i = 0; i < 5; i++) cycle();
        chk("post_reset_no_writes", 32'(wr_log.size()), 32'd0);
        chk("post_reset_inReady",   32'(bus.inReady),   32'd1);

        // ---------------- randomized traffic ----------------
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), $urandom, $urandom,
                  $urandom_range(0, 3) != 0,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
